// File: rtl/ccd_capture.sv
// ccd_capture: raw-Bayer capture front end feeding the imgproc input stream.
// Registers the sensor bus once, gates whole frames under start/stop control,
// and emits pixel data with column/row coordinates plus a captured-frame count.
module ccd_capture #(
  parameter int COLUMN_WIDTH = 1280,
  parameter int DATA_W       = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iEND,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [15:0]       oX_Cont,
  output logic [15:0]       oY_Cont,
  output logic [31:0]       oFrame_Cont
);

  typedef enum logic [1:0] {
    STOPPED,
    WAIT_FRAME,
    IN_FRAME
  } state_e;

  localparam logic [15:0] LastCol = 16'(COLUMN_WIDTH - 1);

  logic              fvalIn_q;
  logic              lvalIn_q;
  logic [DATA_W-1:0] dataIn_q;
  logic              fvalDly_q;
  logic              run_q;
  state_e            state_q;
  logic [15:0]       xPtr_q;
  logic [15:0]       yPtr_q;
  logic [15:0]       xPtr_d;
  logic [15:0]       yPtr_d;
  logic [DATA_W-1:0] data_q;
  logic              dval_q;
  logic [15:0]       xOut_q;
  logic [15:0]       yOut_q;
  logic [31:0]       frameCnt_q;

  logic frameRise;
  logic frameFall;
  logic pixelValid;

  assign frameRise  = fvalIn_q & ~fvalDly_q;
  assign frameFall  = ~fvalIn_q & fvalDly_q;
  assign pixelValid = (state_q == IN_FRAME) & fvalIn_q & lvalIn_q;

  // Single register stage on the sensor pins plus a frame-valid delay for edges.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fvalIn_q  <= 1'b0;
      lvalIn_q  <= 1'b0;
      dataIn_q  <= '0;
      fvalDly_q <= 1'b0;
    end else begin
      fvalIn_q  <= iFVAL;
      lvalIn_q  <= iLVAL;
      dataIn_q  <= iDATA;
      fvalDly_q <= fvalIn_q;
    end
  end

  // Run latch: stop has priority over start when both arrive together.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      run_q <= 1'b0;
    end else if (iEND) begin
      run_q <= 1'b0;
    end else if (iSTART) begin
      run_q <= 1'b1;
    end
  end

  // Next pixel position: wrap on full rows, recover on short lines, clear at frame end.
  always_comb begin
    xPtr_d = xPtr_q;
    yPtr_d = yPtr_q;
    if (state_q == IN_FRAME) begin
      if (frameFall) begin
        xPtr_d = '0;
        yPtr_d = '0;
      end else if (pixelValid) begin
        if (xPtr_q == LastCol) begin
          xPtr_d = '0;
          yPtr_d = yPtr_q + 16'd1;
        end else begin
          xPtr_d = xPtr_q + 16'd1;
        end
      end else if (!lvalIn_q && (xPtr_q != 16'd0)) begin
        xPtr_d = '0;
        yPtr_d = yPtr_q + 16'd1;
      end
    end
  end

  // Frame-gating FSM with registered pixel, coordinate and frame-count outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q    <= STOPPED;
      xPtr_q     <= '0;
      yPtr_q     <= '0;
      data_q     <= '0;
      dval_q     <= 1'b0;
      xOut_q     <= '0;
      yOut_q     <= '0;
      frameCnt_q <= '0;
    end else begin
      xPtr_q <= xPtr_d;
      yPtr_q <= yPtr_d;
      data_q <= dataIn_q;
      dval_q <= pixelValid;
      if (pixelValid) begin
        xOut_q <= xPtr_q;
        yOut_q <= yPtr_q;
      end
      case (state_q)
        STOPPED: begin
          if (run_q) begin
            state_q <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (!run_q) begin
            state_q <= STOPPED;
          end else if (frameRise) begin
            state_q <= IN_FRAME;
          end
        end
        IN_FRAME: begin
          if (frameFall) begin
            frameCnt_q <= frameCnt_q + 32'd1;
            xOut_q     <= '0;
            yOut_q     <= '0;
            state_q    <= run_q ? WAIT_FRAME : STOPPED;
          end
        end
        default: state_q <= STOPPED;
      endcase
    end
  end

  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = xOut_q;
  assign oY_Cont     = yOut_q;
  assign oFrame_Cont = frameCnt_q;

endmodule

// File: tb/tb_ccd_capture.sv
// tb_ccd_capture: directed scenarios plus randomized frames for ccd_capture,
// checked every cycle against a frame-level behavioural model.
module tb_ccd_capture;

  localparam int Col = 4;
  localparam int Dw  = 12;

  logic          iCLK;
  logic          iRST;
  logic [Dw-1:0] iDATA;
  logic          iFVAL;
  logic          iLVAL;
  logic          iSTART;
  logic          iEND;
  logic [Dw-1:0] oDATA;
  logic          oDVAL;
  logic [15:0]   oX_Cont;
  logic [15:0]   oY_Cont;
  logic [31:0]   oFrame_Cont;

  int vectors     = 0;
  int miscompares = 0;

  logic          pendStart = 1'b0;
  logic          pendEnd   = 1'b0;
  logic [Dw-1:0] dataCnt   = '0;

  logic [43:0] pixQ[$];
  logic [43:0] expQ[$];

  // Model view: sensor history and expected outputs after each edge.
  logic          mRun = 1'b0, mWaiting = 1'b0, mCapturing = 1'b0;
  int            mX = 0;
  logic [15:0]   mY = '0;
  logic [31:0]   mFrames = '0;
  logic          f1 = 1'b0, f2 = 1'b0, l1 = 1'b0;
  logic [Dw-1:0] d1 = '0;
  logic          eDval = 1'b0;
  logic [Dw-1:0] eData = '0;
  logic [15:0]   eX = '0, eY = '0;

  ccd_capture #(.COLUMN_WIDTH(Col), .DATA_W(Dw)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iDATA       (iDATA),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .iSTART      (iSTART),
    .iEND        (iEND),
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oFrame_Cont (oFrame_Cont)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Reference model: frames are captured whole once armed, pixels numbered in raster order.
  always @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      mRun = 0; mWaiting = 0; mCapturing = 0; mX = 0; mY = '0; mFrames = '0;
      f1 = 0; f2 = 0; l1 = 0; d1 = '0;
      eDval = 0; eData = '0; eX = '0; eY = '0;
    end else begin
      eDval = mCapturing & f1 & l1;
      eData = d1;
      if (mCapturing && !f1 && f2) begin
        mFrames = mFrames + 32'd1;
        mX = 0; mY = '0; eX = '0; eY = '0;
        mCapturing = 0;
        mWaiting = mRun;
      end else begin
        if (eDval) begin
          eX = 16'(mX);
          eY = mY;
          mX = mX + 1;
          if (mX == Col) begin
            mX = 0;
            mY = mY + 16'd1;
          end
        end else if (mCapturing && !l1 && mX != 0) begin
          mX = 0;
          mY = mY + 16'd1;
        end
        if (mWaiting && !mRun) mWaiting = 0;
        else if (mWaiting && f1 && !f2) begin
          mWaiting = 0;
          mCapturing = 1;
        end else if (!mWaiting && !mCapturing && mRun) mWaiting = 1;
      end
      if (iEND) mRun = 0;
      else if (iSTART) mRun = 1;
      f2 = f1; f1 = iFVAL; l1 = iLVAL; d1 = iDATA;
    end
  end

  // Cycle compare against the model, and log of every emitted pixel.
  always @(negedge iCLK) begin
    vectors++;
    if ({oDVAL, oDATA, oX_Cont, oY_Cont, oFrame_Cont} !== {eDval, eData, eX, eY, mFrames}) begin
      miscompares++;
      $display("[TB] FAIL cycle t=%0t dval=%b/%b data=%h/%h x=%0d/%0d y=%0d/%0d frames=%0d/%0d (actual/expected)",
               $time, oDVAL, eDval, oDATA, eData, oX_Cont, eX, oY_Cont, eY, oFrame_Cont, mFrames);
    end
    if (oDVAL === 1'b1) pixQ.push_back({oX_Cont, oY_Cont, oDATA});
  end

  function automatic logic [43:0] pk(input int x, input int y, input int d);
    return {16'(x), 16'(y), 12'(d)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkPixels(input string name);
    checkOutput({name, " count"}, 64'(pixQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < pixQ.size(); i++)
      checkOutput($sformatf("%s pix%0d", name, i), 64'(pixQ[i]), 64'(expQ[i]));
  endtask

  task automatic applyStimulus(input logic fv, input logic lv, input logic [Dw-1:0] d);
    @(posedge iCLK);
    #1;
    iFVAL  = fv;
    iLVAL  = lv;
    iDATA  = d;
    iSTART = pendStart;
    iEND   = pendEnd;
    pendStart = 1'b0;
    pendEnd   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, Dw'($urandom));
  endtask

  task automatic frameStart();
    repeat (2) applyStimulus(1'b1, 1'b0, Dw'($urandom));
  endtask

  task automatic frameEnd();
    applyStimulus(1'b0, 1'b0, Dw'($urandom));
    idle(4);
  endtask

  task automatic sendLine(input int len, input int endAt, input int gap);
    for (int i = 0; i < len; i++) begin
      if (i == endAt) pendEnd = 1'b1;
      applyStimulus(1'b1, 1'b1, dataCnt);
      dataCnt = dataCnt + 1'b1;
    end
    repeat (gap) applyStimulus(1'b1, 1'b0, Dw'($urandom));
  endtask

  initial begin
    iRST = 1'b0; iFVAL = 0; iLVAL = 0; iSTART = 0; iEND = 0; iDATA = '0;
    repeat (3) @(posedge iCLK);
    #1;
    checkOutput("reset dval", 64'(oDVAL), 64'd0);
    checkOutput("reset data", 64'(oDATA), 64'd0);
    checkOutput("reset frames", 64'(oFrame_Cont), 64'd0);
    iRST = 1'b1;

    // Basic frame: two full rows of four pixels with data 1..8.
    pendStart = 1'b1; idle(3);
    pixQ.delete(); dataCnt = 12'd1;
    frameStart(); sendLine(4, -1, 2); sendLine(4, -1, 2); frameEnd();
    expQ = '{pk(0,0,1), pk(1,0,2), pk(2,0,3), pk(3,0,4), pk(0,1,5), pk(1,1,6), pk(2,1,7), pk(3,1,8)};
    checkPixels("basic");
    checkOutput("basic frames", 64'(oFrame_Cont), 64'd1);

    // Short line: two pixels then a full row.
    pixQ.delete(); dataCnt = 12'd1;
    frameStart(); sendLine(2, -1, 2); sendLine(4, -1, 2); frameEnd();
    expQ = '{pk(0,0,1), pk(1,0,2), pk(0,1,3), pk(1,1,4), pk(2,1,5), pk(3,1,6)};
    checkPixels("shortline");
    checkOutput("shortline frames", 64'(oFrame_Cont), 64'd2);

    // Stop requested during row 0: frame finishes, the following one is ignored.
    pixQ.delete(); dataCnt = 12'd1;
    frameStart(); sendLine(4, 1, 2); sendLine(4, -1, 2); sendLine(4, -1, 2); frameEnd();
    checkOutput("stop count", 64'(pixQ.size()), 64'd12);
    if (pixQ.size() == 12) checkOutput("stop last", 64'(pixQ[11]), 64'(pk(3, 2, 12)));
    checkOutput("stop frames", 64'(oFrame_Cont), 64'd3);
    pixQ.delete();
    frameStart(); sendLine(4, -1, 2); frameEnd();
    checkOutput("stopped count", 64'(pixQ.size()), 64'd0);

    // Late arm: start mid-frame captures nothing until the next frame.
    pixQ.delete(); dataCnt = 12'd1;
    frameStart(); sendLine(4, -1, 2); pendStart = 1'b1; sendLine(4, -1, 2); frameEnd();
    checkOutput("latearm count", 64'(pixQ.size()), 64'd0);
    dataCnt = 12'd1;
    frameStart(); sendLine(4, -1, 2); frameEnd();
    expQ = '{pk(0,0,1), pk(1,0,2), pk(2,0,3), pk(3,0,4)};
    checkPixels("latearm next");
    checkOutput("latearm frames", 64'(oFrame_Cont), 64'd4);

    // Start and end together: stays stopped; a later start alone arms.
    pendStart = 1'b1; pendEnd = 1'b1; idle(3);
    pixQ.delete();
    frameStart(); sendLine(4, -1, 2); frameEnd();
    checkOutput("simul count", 64'(pixQ.size()), 64'd0);
    pendStart = 1'b1; idle(3);
    frameStart(); sendLine(4, -1, 2); frameEnd();
    checkOutput("simul rearm count", 64'(pixQ.size()), 64'd4);
    checkOutput("simul frames", 64'(oFrame_Cont), 64'd5);

    // Reset during row 1: outputs clear at once, capture needs a fresh start.
    pendStart = 1'b1; idle(3);
    frameStart(); sendLine(4, -1, 2);
    applyStimulus(1'b1, 1'b1, 12'h0AA);
    applyStimulus(1'b1, 1'b1, 12'h0AB);
    #2 iRST = 1'b0;
    #1;
    checkOutput("midreset dval", 64'(oDVAL), 64'd0);
    checkOutput("midreset data", 64'(oDATA), 64'd0);
    checkOutput("midreset x", 64'(oX_Cont), 64'd0);
    checkOutput("midreset y", 64'(oY_Cont), 64'd0);
    checkOutput("midreset frames", 64'(oFrame_Cont), 64'd0);
    @(posedge iCLK);
    #1 iRST = 1'b1;
    pixQ.delete();
    sendLine(2, -1, 2); frameEnd();
    frameStart(); sendLine(4, -1, 2); frameEnd();
    checkOutput("postreset count", 64'(pixQ.size()), 64'd0);
    checkOutput("postreset frames", 64'(oFrame_Cont), 64'd0);
    pendStart = 1'b1; idle(3);
    frameStart(); sendLine(4, -1, 2); frameEnd();
    checkOutput("postreset rearm", 64'(oFrame_Cont), 64'd1);

    // Randomized frames with random line lengths, arming and stop requests.
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 2) != 0) pendStart = 1'b1;
      idle($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) pendStart = 1'b1;
      repeat ($urandom_range(1, 2)) applyStimulus(1'b1, 1'b0, Dw'($urandom));
      for (int l = 0; l < int'($urandom_range(1, 4)); l++) begin
        int len;
        len = $urandom_range(1, 9);
        dataCnt = Dw'($urandom);
        if ($urandom_range(0, 6) == 0) pendStart = 1'b1;
        sendLine(len, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                 $urandom_range(1, 2));
      end
      applyStimulus(1'b0, 1'b0, Dw'($urandom));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
